eth_tx_sched: RTL and testbench

- Frame-payload scheduler in front of the Ethernet TX packer.
- Arbitrates between two show-ahead byte FIFOs (source A, source B) at frame granularity, round-robin.
- Serializes the granted source's bytes into dibits on the packer's axiiv/axiid input, paced by the packer's stall output.
- Prepends a 1-byte channel tag to each payload so the receiver can demux; sends a pad frame when no source has a full payload.

---
 rtl/eth_tx_sched.sv | 134 +++++++++++++
 tb/tb_eth_tx_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: frame-level round-robin scheduler between two show-ahead byte
// FIFOs. Each frame is one tag byte plus NEED data bytes, sent as dibits
// (LSB pair first) on the packer's axiiv/axiid input, paced by its stall.
// A pad frame (tag and data all TAG_PAD / zero) goes out when neither source
// holds a full payload.
module eth_tx_sched #(
  parameter int         PAYLOAD_BYTES = 5,
  parameter int         COUNT_W       = 10,
  parameter logic [7:0] TAG_A         = 8'hA1,
  parameter logic [7:0] TAG_B         = 8'hB2,
  parameter logic [7:0] TAG_PAD       = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  output logic               axiiv,
  output logic [1:0]         axiid,
  input  logic [7:0]         a_data,
  input  logic [COUNT_W-1:0] a_count,
  output logic               a_rd,
  input  logic [7:0]         b_data,
  input  logic [COUNT_W-1:0] b_count,
  output logic               b_rd,
  output logic [1:0]         owner,
  output logic [15:0]        frames_a,
  output logic [15:0]        frames_b,
  output logic [15:0]        frames_pad,
  output logic [7:0]         aborts
);

  localparam int TOTAL = 4 * PAYLOAD_BYTES;
  localparam int NEED  = PAYLOAD_BYTES - 1;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [1:0] OWN_PAD = 2'd0;
  localparam logic [1:0] OWN_A   = 2'd1;
  localparam logic [1:0] OWN_B   = 2'd2;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   dibit_cnt;
  logic [1:0]         last_owner;

  logic               a_elig, b_elig;
  logic               frame_done;
  logic [1:0]         last_next;
  logic [1:0]         owner_sel;
  logic               active;
  logic [CNT_W-3:0]   byte_idx;
  logic [1:0]         pair;
  logic [7:0]         cur_byte;
  logic [7:0]         shifted;

  assign a_elig     = (a_count >= COUNT_W'(NEED));
  assign b_elig     = (b_count >= COUNT_W'(NEED));
  assign frame_done = (state != IDLE) && stall && (dibit_cnt == CNT_W'(TOTAL));
  assign byte_idx   = dibit_cnt[CNT_W-1:2];
  assign pair       = dibit_cnt[1:0];

  // Arbitration uses the post-completion last_owner so a one-cycle stall gap
  // between frames already sees the rotated priority.
  always_comb begin
    last_next = last_owner;
    if (frame_done && (owner == OWN_A || owner == OWN_B))
      last_next = owner;
    owner_sel = OWN_PAD;
    if (a_elig && b_elig)
      owner_sel = (last_next == OWN_A) ? OWN_B : OWN_A;
    else if (a_elig)
      owner_sel = OWN_A;
    else if (b_elig)
      owner_sel = OWN_B;
  end

  // Dibit mux: tag in byte 0, owner's head byte afterwards, LSB pair first.
  always_comb begin
    active = !rst && !stall && (dibit_cnt < CNT_W'(TOTAL));
    if (byte_idx == '0) begin
      case (owner)
        OWN_A:   cur_byte = TAG_A;
        OWN_B:   cur_byte = TAG_B;
        default: cur_byte = TAG_PAD;
      endcase
    end else begin
      case (owner)
        OWN_A:   cur_byte = a_data;
        OWN_B:   cur_byte = b_data;
        default: cur_byte = 8'h00;
      endcase
    end
    shifted = cur_byte >> {pair, 1'b0};
    axiiv   = active;
    axiid   = active ? shifted[1:0] : 2'b00;
    a_rd    = active && (owner == OWN_A) && (byte_idx != '0) && (pair == 2'd3);
    b_rd    = active && (owner == OWN_B) && (byte_idx != '0) && (pair == 2'd3);
  end

  // Frame FSM: count dibits while stall is low, settle statistics when it rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dibit_cnt  <= '0;
      owner      <= OWN_PAD;
      last_owner <= OWN_B;
      frames_a   <= '0;
      frames_b   <= '0;
      frames_pad <= '0;
      aborts     <= '0;
    end else if (stall) begin
      if (state != IDLE) begin
        if (dibit_cnt == CNT_W'(TOTAL)) begin
          case (owner)
            OWN_A:   frames_a   <= frames_a + 16'd1;
            OWN_B:   frames_b   <= frames_b + 16'd1;
            default: frames_pad <= frames_pad + 16'd1;
          endcase
        end else if (dibit_cnt != '0 && aborts != 8'hFF) begin
          aborts <= aborts + 8'd1;
        end
      end
      last_owner <= last_next;
      owner      <= owner_sel;
      dibit_cnt  <= '0;
      state      <= IDLE;
    end else if (dibit_cnt < CNT_W'(TOTAL)) begin
      dibit_cnt <= dibit_cnt + 1'b1;
      state     <= (dibit_cnt == CNT_W'(TOTAL - 1)) ? DONE : SEND;
    end else begin
      state <= DONE;
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: byte FIFOs modelled as queues, each frame's expected
// dibit stream derived from the queue contents and the round-robin rule.
module tb_eth_tx_sched;

  localparam int PB    = 5;
  localparam int TOTAL = 4 * PB;
  localparam int NEED  = PB - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        axiiv;
  logic [1:0]  axiid;
  logic [7:0]  a_data, b_data;
  logic [9:0]  a_count, b_count;
  logic        a_rd, b_rd;
  logic [1:0]  owner;
  logic [15:0] frames_a, frames_b, frames_pad;
  logic [7:0]  aborts;

  eth_tx_sched dut (
    .clk(clk), .rst(rst), .stall(stall), .axiiv(axiiv), .axiid(axiid),
    .a_data(a_data), .a_count(a_count), .a_rd(a_rd),
    .b_data(b_data), .b_count(b_count), .b_rd(b_rd),
    .owner(owner), .frames_a(frames_a), .frames_b(frames_b),
    .frames_pad(frames_pad), .aborts(aborts)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  int m_fa, m_fb, m_fp, m_ab, m_last;

  logic       s_v, s_ard, s_brd;
  logic [1:0] s_d, s_own;

  task automatic refresh();
    a_data  = (qa.size() > 0) ? qa[0] : 8'h00;
    b_data  = (qb.size() > 0) ? qb[0] : 8'h00;
    a_count = 10'(qa.size());
    b_count = 10'(qb.size());
  endtask

  // One clock: drive stall, sample outputs mid-cycle, pop FIFOs after the edge.
  task automatic step(input logic s);
    stall = s;
    refresh();
    #5;
    s_v = axiiv; s_d = axiid; s_ard = a_rd; s_brd = b_rd; s_own = owner;
    @(posedge clk);
    #1;
    if (s_ard && qa.size() > 0) void'(qa.pop_front());
    if (s_brd && qb.size() > 0) void'(qb.pop_front());
    refresh();
  endtask

  task automatic fill(input int na, input int nb);
    for (int k = 0; k < na; k++) qa.push_back(8'($urandom));
    for (int k = 0; k < nb; k++) qb.push_back(8'($urandom));
  endtask

  // One idle cycle, n_low stall-low cycles, then stall rises to close the frame.
  task automatic run_frame(input int n_low, input string name);
    logic [7:0] bytes[PB];
    logic [7:0] sh;
    logic [1:0] eo, ed;
    logic       ev, ear, ebr, ae, be;
    step(1'b1);
    ae = qa.size() >= NEED;
    be = qb.size() >= NEED;
    if (ae && be) eo = (m_last == 1) ? 2'd2 : 2'd1;
    else if (ae)  eo = 2'd1;
    else if (be)  eo = 2'd2;
    else          eo = 2'd0;
    bytes[0] = (eo == 2'd1) ? 8'hA1 : (eo == 2'd2) ? 8'hB2 : 8'h00;
    for (int k = 1; k < PB; k++)
      bytes[k] = (eo == 2'd1) ? qa[k-1] : (eo == 2'd2) ? qb[k-1] : 8'h00;
    for (int i = 0; i < n_low; i++) begin
      step(1'b0);
      ev  = (i < TOTAL);
      sh  = bytes[ev ? i / 4 : 0] >> (2 * (i % 4));
      ed  = ev ? sh[1:0] : 2'b00;
      ear = ev && eo == 2'd1 && i >= 4 && (i % 4) == 3;
      ebr = ev && eo == 2'd2 && i >= 4 && (i % 4) == 3;
      checks++;
      if ({s_v, s_d, s_ard, s_brd, s_own} !== {ev, ed, ear, ebr, eo}) begin
        failures++;
        $display("FAIL %s dibit %0d: got v=%b d=%b ard=%b brd=%b own=%0d, want v=%b d=%b ard=%b brd=%b own=%0d",
                 name, i, s_v, s_d, s_ard, s_brd, s_own, ev, ed, ear, ebr, eo);
      end
      checks++;
      if (s_ard && s_brd) begin
        failures++;
        $display("FAIL %s rd_overlap dibit %0d: got a_rd=1 b_rd=1, want not both", name, i);
      end
    end
    step(1'b1);
    if (n_low >= TOTAL) begin
      if (eo == 2'd1) begin m_fa = (m_fa + 1) & 16'hFFFF; m_last = 1; end
      else if (eo == 2'd2) begin m_fb = (m_fb + 1) & 16'hFFFF; m_last = 2; end
      else m_fp = (m_fp + 1) & 16'hFFFF;
    end else if (n_low > 0 && m_ab < 255) begin
      m_ab++;
    end
    checks++;
    if ({frames_a, frames_b, frames_pad, aborts} !== {16'(m_fa), 16'(m_fb), 16'(m_fp), 8'(m_ab)}) begin
      failures++;
      $display("FAIL %s counters: got a=%0d b=%0d pad=%0d ab=%0d, want a=%0d b=%0d pad=%0d ab=%0d",
               name, frames_a, frames_b, frames_pad, aborts, m_fa, m_fb, m_fp, m_ab);
    end
  endtask

  task automatic model_reset();
    m_fa = 0; m_fb = 0; m_fp = 0; m_ab = 0; m_last = 2;
  endtask

  task automatic test_reset();
    qa.delete(); qb.delete();
    rst = 1'b1; stall = 1'b1; refresh();
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({axiiv, axiid, a_rd, b_rd, owner, frames_a, frames_b, frames_pad, aborts} !== '0) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%b ard=%b brd=%b own=%0d fa=%0d fb=%0d fp=%0d ab=%0d, want all 0",
               axiiv, axiid, a_rd, b_rd, owner, frames_a, frames_b, frames_pad, aborts);
    end
    rst = 1'b0;
    step(1'b1);
  endtask

  task automatic test_single_a();
    qa.delete(); qb.delete();
    fill(10, 0);
    run_frame(TOTAL, "single_a");
    checks++;
    if (qa.size() != 6) begin
      failures++;
      $display("FAIL single_a_pops: got remaining=%0d, want 6", qa.size());
    end
  endtask

  task automatic test_round_robin();
    int fa0, fb0;
    qa.delete(); qb.delete();
    fill(12, 12);
    fa0 = m_fa; fb0 = m_fb;
    for (int f = 0; f < 4; f++) run_frame(TOTAL + int'($urandom_range(0, 4)), "round_robin");
    checks++;
    if (frames_a !== 16'(fa0 + 2) || frames_b !== 16'(fb0 + 2)) begin
      failures++;
      $display("FAIL round_robin_split: got fa=%0d fb=%0d, want fa=%0d fb=%0d",
               frames_a, frames_b, fa0 + 2, fb0 + 2);
    end
  endtask

  task automatic test_pad();
    qa.delete(); qb.delete();
    fill(3, 3);
    run_frame(TOTAL, "pad");
    checks++;
    if (qa.size() != 3 || qb.size() != 3 || owner !== 2'd0) begin
      failures++;
      $display("FAIL pad_no_pop: got qa=%0d qb=%0d owner=%0d, want 3 3 0", qa.size(), qb.size(), owner);
    end
  endtask

  task automatic test_abort();
    qa.delete(); qb.delete();
    fill(9, 0);
    run_frame(9, "abort");
    checks++;
    if (qa.size() != 8) begin
      failures++;
      $display("FAIL abort_pops: got remaining=%0d, want 8", qa.size());
    end
    run_frame(TOTAL, "after_abort");
  endtask

  task automatic test_done_tail();
    qa.delete(); qb.delete();
    fill(4, 4);
    run_frame(24, "done_tail");
  endtask

  task automatic test_reset_mid();
    qa.delete(); qb.delete();
    fill(8, 8);
    step(1'b1);
    for (int i = 0; i < 6; i++) step(1'b0);
    rst = 1'b1;
    #2;
    model_reset();
    checks++;
    if ({axiiv, axiid, a_rd, b_rd, owner, frames_a, frames_b, frames_pad, aborts} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b d=%b ard=%b brd=%b own=%0d fa=%0d fb=%0d fp=%0d ab=%0d, want all 0",
               axiiv, axiid, a_rd, b_rd, owner, frames_a, frames_b, frames_pad, aborts);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(TOTAL, "after_reset");
    checks++;
    if (frames_a !== 16'd1) begin
      failures++;
      $display("FAIL after_reset_tie: got frames_a=%0d, want 1", frames_a);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      fill(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      run_frame(int'($urandom_range(5, 24)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_pad();
    test_abort();
    test_done_tail();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
